// File: rtl/bram_pixel_reader_if.sv
// Bus bundle for bram_pixel_reader: BRAM read port (addr/channel/data) plus the pixel stream.
// Stream rule: a pixel transfers on a rising edge where pix_valid && pix_ready; while pix_valid is
// high and pix_ready is low, pix_data/pix_last hold stable and pix_valid does not drop.
interface bram_pixel_reader_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_channel;
    logic [7:0]        mem_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [23:0]       pix_data;
    logic              pix_last;

    modport master (
        output mem_addr, mem_channel, pix_valid, pix_data, pix_last,
        input  mem_data, pix_ready
    );

    modport slave (
        input  mem_addr, mem_channel, pix_valid, pix_data, pix_last,
        output mem_data, pix_ready
    );
endinterface

// File: rtl/bram_pixel_reader.sv
// Frame-scan reader: walks every pixel address, reads R/G/B from the image BRAM (1-cycle latency)
// and emits one packed {R,G,B} word per pixel on a valid/ready stream.
module bram_pixel_reader #(
    parameter int IMG_PIXELS = 76800,
    parameter int ADDR_W     = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state,
    bram_pixel_reader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_R  = 3'd1,
        REQ_G  = 3'd2,
        REQ_B  = 3'd3,
        WAIT_B = 3'd4,
        OUT    = 3'd5
    } state_t;

    localparam logic [1:0]        CH_R      = 2'b01;
    localparam logic [1:0]        CH_G      = 2'b10;
    localparam logic [1:0]        CH_B      = 2'b00;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [1:0]        chan_q, chan_n;
    logic [7:0]        r_q, r_n, g_q, g_n;
    logic              pv_q, pv_n, pl_q, pl_n;
    logic [23:0]       pd_q, pd_n;
    logic              busy_q, busy_n, done_q, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            chan_q <= CH_B;
            r_q    <= '0;
            g_q    <= '0;
            pv_q   <= 1'b0;
            pd_q   <= '0;
            pl_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            chan_q <= chan_n;
            r_q    <= r_n;
            g_q    <= g_n;
            pv_q   <= pv_n;
            pd_q   <= pd_n;
            pl_q   <= pl_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    // Each data capture takes the BRAM result of the channel presented one state earlier.
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        chan_n  = chan_q;
        r_n     = r_q;
        g_n     = g_q;
        pv_n    = pv_q;
        pd_n    = pd_q;
        pl_n    = pl_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = REQ_R;
                    addr_n  = '0;
                    chan_n  = CH_R;
                    busy_n  = 1'b1;
                end
            end
            REQ_R: begin
                state_n = REQ_G;
                chan_n  = CH_G;
            end
            REQ_G: begin
                r_n     = bus.mem_data;
                state_n = REQ_B;
                chan_n  = CH_B;
            end
            REQ_B: begin
                g_n     = bus.mem_data;
                state_n = WAIT_B;
            end
            WAIT_B: begin
                pd_n    = {r_q, g_q, bus.mem_data};
                pv_n    = 1'b1;
                pl_n    = (addr_q == LAST_ADDR);
                state_n = OUT;
            end
            OUT: begin
                if (pv_q && bus.pix_ready) begin
                    pv_n = 1'b0;
                    pl_n = 1'b0;
                    if (pl_q) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        addr_n  = '0;
                        chan_n  = CH_B;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = REQ_R;
                        addr_n  = addr_q + ADDR_W'(1);
                        chan_n  = CH_R;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Abort overrides both the stream handshake and any new start.
        if (abort && state != IDLE) begin
            state_n = IDLE;
            addr_n  = '0;
            chan_n  = CH_B;
            pv_n    = 1'b0;
            pl_n    = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_channel = chan_q;
    assign bus.pix_valid   = pv_q;
    assign bus.pix_data    = pd_q;
    assign bus.pix_last    = pl_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_bram_pixel_reader.sv
// Bench for bram_pixel_reader on a 16-pixel frame: a queue-based pixel model checked every cycle,
// plus directed scenarios for latency, stall, ignored start, abort and asynchronous reset.
module tb_bram_pixel_reader;
    localparam int NPIX = 16;
    localparam int AW   = 19;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    bram_pixel_reader_if #(.ADDR_W(AW)) bus ();

    bram_pixel_reader #(.IMG_PIXELS(NPIX), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Image BRAM: registered read, R=addr, G=~addr, B=5A, channel 00 is the blue arm.
    always @(posedge clk) begin
        case (bus.mem_channel)
            2'b01:   bus.mem_data <= bus.mem_addr[7:0];
            2'b10:   bus.mem_data <= ~bus.mem_addr[7:0];
            default: bus.mem_data <= 8'h5A;
        endcase
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];
    logic        done_exp = 1'b0;
    int          ph = 0;
    logic [AW-1:0] ph_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pix_of(input int i);
        logic [7:0] a;
        a = 8'(i);
        return {a, ~a, 8'h5A};
    endfunction

    // Per-cycle compare against the frame model.
    always @(negedge clk) begin
        int idx;
        if (rst) begin
            done_exp = 1'b0;
            ph       = 0;
        end else begin
            check("done", {31'd0, done}, {31'd0, done_exp});
            done_exp = 1'b0;
            if (bus.pix_valid) begin
                check("done_with_valid", {31'd0, done}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pix_unexpected: got data %0h with empty model at %0t", bus.pix_data, $time);
                end else begin
                    idx = NPIX - exp_q.size();
                    check("pix_data", {8'd0, bus.pix_data}, {8'd0, exp_q[0]});
                    check("pix_last", {31'd0, bus.pix_last}, {31'd0, idx == NPIX - 1});
                    check("pix_addr", 32'(bus.mem_addr), 32'(idx));
                    if (bus.pix_ready) begin
                        void'(exp_q.pop_front());
                        if (idx == NPIX - 1) done_exp = 1'b1;
                    end
                end
            end
            if (busy) begin
                if (ph == 1) begin
                    check("ch_g", {30'd0, bus.mem_channel}, 32'd2);
                    check("addr_g", 32'(bus.mem_addr), 32'(ph_addr));
                    ph = 2;
                end else if (ph == 2) begin
                    check("ch_b", {30'd0, bus.mem_channel}, 32'd0);
                    check("addr_b", 32'(bus.mem_addr), 32'(ph_addr));
                    ph = 0;
                end else if (bus.mem_channel == 2'b01) begin
                    ph      = 1;
                    ph_addr = bus.mem_addr;
                end
            end else begin
                ph = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.pix_valid && n < 40) begin
            tick();
            n++;
        end
        if (!bus.pix_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid: pix_valid still 0 after %0d cycles at %0t", n, $time);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(pix_of(i));
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input bit chk_spacing);
        int n;
        for (int i = 0; i < NPIX; i++) begin
            wait_valid(n);
            if (chk_spacing) check("spacing", 32'(n), 32'd4);
            if (i == 0) check("pix0_lit", {8'd0, bus.pix_data}, 32'h0000FF5A);
            if (i == 3) check("pix3_lit", {8'd0, bus.pix_data}, 32'h0003FC5A);
            tick();
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        tick();
        check("done_1cyc", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  found;
        rst           = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        bus.pix_ready = 1'b0;

        // Reset with no clock edge yet.
        #1 rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_chan", {30'd0, bus.mem_channel}, 32'd0);
        check("rst_valid", {31'd0, bus.pix_valid}, 32'd0);
        check("rst_data", {8'd0, bus.pix_data}, 32'd0);
        check("rst_last", {31'd0, bus.pix_last}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_addr", 32'(bus.mem_addr), 32'd0);

        // Full frame with pix_ready held high.
        bus.pix_ready = 1'b1;
        start_frame();
        run_frame(1'b1);
        check("model_empty_a", 32'(exp_q.size()), 32'd0);

        // Ignored start at pixel 2, stall at pixel 3, abort at pixel 5 in REQ_G.
        repeat (3) tick();
        start_frame();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check("busy_after_start", {31'd0, busy}, 32'd1);
            end
            if (i == 3) bus.pix_ready = 1'b0;
            wait_valid(n);
            if (i == 3) begin
                for (int k = 0; k < 7; k++) begin
                    check("stall_valid", {31'd0, bus.pix_valid}, 32'd1);
                    check("stall_data", {8'd0, bus.pix_data}, 32'h0003FC5A);
                    check("stall_addr", 32'(bus.mem_addr), 32'd3);
                    tick();
                end
                bus.pix_ready = 1'b1;
            end
            tick();
        end
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (bus.mem_channel == 2'b10 && bus.mem_addr == AW'(5)) found = 1'b1;
            else tick();
        end
        check("abort_reached_req_g", {31'd0, found}, 32'd1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        exp_q.delete();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, bus.pix_valid}, 32'd0);
        check("abort_addr", 32'(bus.mem_addr), 32'd0);
        check("abort_chan", {30'd0, bus.mem_channel}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (3) tick();
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
        start_frame();
        run_frame(1'b1);

        // Asynchronous reset while a pixel is waiting in OUT.
        bus.pix_ready = 1'b0;
        start_frame();
        wait_valid(n);
        check("pre_rst_valid", {31'd0, bus.pix_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.pix_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_addr", 32'(bus.mem_addr), 32'd0);
        check("arst_data", {8'd0, bus.pix_data}, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        bus.pix_ready = 1'b1;
        start_frame();
        run_frame(1'b1);
        check("model_empty_end", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
